// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers the pixel column and line from a pair of
// active-low VGA sync inputs. Free-running counters are re-phased on every
// sync falling edge, and a small FSM decides when the recovered timing can be
// trusted (locked). Any timing violation while locked raises a one-cycle
// sync_error pulse. The pulse is also counted in a saturating counter.
//
// Timing parameters default to 640x480@60. All outputs are decoded from
// registered state, so each output lags the sync inputs by exactly one cycle.
module vga_sync_decoder #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int V_TOTAL      = 525,
    parameter int LOCK_LINES   = 4
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] H_Count_Out,
    output logic [9:0] V_Count_Out,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_error,
    output logic [7:0] error_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE   = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE   = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [2:0] LOCK_MIN = 3'(LOCK_LINES);
    // The timeout counter wraps naturally: 1024 cycles without an hsync fall.
    localparam logic [9:0] TMO_LAST = 10'd1023;

    state_t     state;
    logic       hs_q, vs_q;
    logic       hs_prev, vs_prev;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_next, v_next;
    logic [2:0] good_cnt;
    logic [9:0] tmo_cnt;
    logic       hs_fall, hs_rise, vs_fall, vs_rise;
    logic       mismatch, timeout;

    // Input capture and edge history; idle level of both syncs is high.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            hs_q    <= hsync_in;
            vs_q    <= vsync_in;
            hs_prev <= hs_q;
            vs_prev <= vs_q;
        end
    end

    // Edge detection, counter forcing and timing checks for the current cycle.
    always_comb begin
        hs_fall = hs_prev & ~hs_q;
        hs_rise = ~hs_prev & hs_q;
        vs_fall = vs_prev & ~vs_q;
        vs_rise = ~vs_prev & vs_q;

        // A falling sync edge re-phases its counter in the same cycle.
        H_Count_Out = hs_fall ? H_SS : h_cnt;
        V_Count_Out = vs_fall ? V_SS : v_cnt;

        // Checks compare against the free-running value, before forcing.
        mismatch = (hs_fall && (h_cnt != H_SS))
                || (vs_fall && ((v_cnt != V_SS) || (H_Count_Out != 10'd0)))
                || (hs_rise && (h_cnt != H_SE))
                || (vs_rise && (v_cnt != V_SE));

        timeout = !hs_fall && (tmo_cnt == TMO_LAST);
    end

    // Next position: counters continue from the (possibly forced) outputs.
    always_comb begin
        h_next = (H_Count_Out == H_LAST) ? 10'd0 : H_Count_Out + 10'd1;
        v_next = V_Count_Out;
        if (H_Count_Out == H_LAST) begin
            v_next = (V_Count_Out == V_LAST) ? 10'd0 : V_Count_Out + 10'd1;
        end
    end

    // Position counters run in every state.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Cycles since the last hsync falling edge.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (hs_fall || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
        end
    end

    // Lock FSM: SEARCH waits for hsync, ACQUIRE counts good lines, LOCKED tracks.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else if (timeout) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (hs_fall) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    if (mismatch) begin
                        good_cnt <= '0;
                    end else begin
                        if (hs_fall && (good_cnt != 3'd7)) begin
                            good_cnt <= good_cnt + 3'd1;
                        end
                        if (vs_fall && (good_cnt >= LOCK_MIN)) begin
                            state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        state <= SEARCH;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    // Saturating count of error pulses; only reset clears it.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            error_count <= '0;
        end else if (sync_error && (error_count != 8'hFF)) begin
            error_count <= error_count + 8'd1;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        locked      = (state == LOCKED);
        sync_error  = locked && (mismatch || timeout);
        video_on    = locked && (H_Count_Out < H_ACT) && (V_Count_Out < V_ACT);
        frame_start = locked && (H_Count_Out == 10'd0) && (V_Count_Out == 10'd0);
        state_dbg   = state;
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for vga_sync_decoder.
// dut_a runs the default 640x480 timing for the first few lines.
// dut_b uses a scaled-down raster so that whole frames fit in a short run:
// 16 columns, 8 lines, hsync low at 10..11, vsync low on line 5.
module tb_vga_sync_decoder;

    localparam int HA = 8;
    localparam int HSS = 10;
    localparam int HSE = 12;
    localparam int HT = 16;
    localparam int VA = 4;
    localparam int VSS = 5;
    localparam int VSE = 6;
    localparam int VT = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       hs_a, vs_a, hs_b, vs_b;
    logic [9:0] h_a, v_a, h_b, v_b;
    logic       vid_a, lk_a, fs_a, se_a, vid_b, lk_b, fs_b, se_b;
    logic [7:0] ec_a, ec_b;
    logic [1:0] st_a, st_b;

    vga_sync_decoder dut_a (
        .clk_25MHz(clk), .rst_n(rst_n), .hsync_in(hs_a), .vsync_in(vs_a),
        .H_Count_Out(h_a), .V_Count_Out(v_a), .video_on(vid_a), .locked(lk_a),
        .frame_start(fs_a), .sync_error(se_a), .error_count(ec_a), .state_dbg(st_a)
    );

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
        .LOCK_LINES(4)
    ) dut_b (
        .clk_25MHz(clk), .rst_n(rst_n), .hsync_in(hs_b), .vsync_in(vs_b),
        .H_Count_Out(h_b), .V_Count_Out(v_b), .video_on(vid_b), .locked(lk_b),
        .frame_start(fs_b), .sync_error(se_b), .error_count(ec_b), .state_dbg(st_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not seen within cycle budget", name);
    endtask

    // ---------------- drivers ----------------
    int gah = 0, gav = 0, vah = -1, vav = -1;
    int gbh = 0, gbv = 0, vbh = -1, vbv = -1;
    int early_b = 0;
    bit hold_b = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 640x480 position to dut_a; afterwards outputs show that position.
    task automatic step_a();
        hs_a = !(gah >= 656 && gah < 752);
        vs_a = !(gav >= 490 && gav < 492);
        tick();
        vah = gah;
        vav = gav;
        if (gah == 799) begin
            gah = 0;
            gav = (gav == 524) ? 0 : gav + 1;
        end else begin
            gah++;
        end
    endtask

    // Drive one scaled position to dut_b; early_b pulls the hsync fall earlier.
    task automatic step_b();
        hs_b = hold_b || !(gbh >= HSS - early_b && gbh < HSE);
        vs_b = !(gbv >= VSS && gbv < VSE);
        tick();
        vbh = gbh;
        vbv = gbv;
        if (gbh == HT - 1) begin
            gbh = 0;
            gbv = (gbv == VT - 1) ? 0 : gbv + 1;
        end else begin
            gbh++;
        end
    endtask

    task automatic run_to_a(input int v, input int h);
        int n = 0;
        while (!(vav == v && vah == h) && n < 4000) begin
            step_a();
            n++;
        end
        if (!(vav == v && vah == h)) bound_fail("run_to_a");
    endtask

    task automatic run_to_b(input int v, input int h);
        int n = 0;
        while (!(vbv == v && vbh == h) && n < 4000) begin
            step_b();
            n++;
        end
        if (!(vbv == v && vbh == h)) bound_fail("run_to_b");
    endtask

    typedef struct {
        int steps;
        int h;
        int v;
        int lk;
        int vid;
        int fs;
        int se;
        int ec;
    } vec_t;

    vec_t tbl[12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cnt_fs, cnt_vid, cnt_se, steps, total_err;
        logic [7:0] e;

        // Checkpoints after reset on dut_b: {steps, H, V, locked, video_on,
        // frame_start, sync_error, error_count}. Before the first hsync fall the
        // counters free-run from reset, one count ahead of the raster.
        tbl[0]  = '{10, 10, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,  10, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1,  11, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{63, 10, 4, 0, 0, 0, 0, 0};
        tbl[4]  = '{6,  0,  5, 0, 0, 0, 0, 0};
        tbl[5]  = '{1,  1,  5, 1, 0, 0, 0, 0};
        tbl[6]  = '{46, 15, 7, 1, 0, 0, 0, 0};
        tbl[7]  = '{1,  0,  0, 1, 1, 1, 0, 0};
        tbl[8]  = '{7,  7,  0, 1, 1, 0, 0, 0};
        tbl[9]  = '{1,  8,  0, 1, 0, 0, 0, 0};
        tbl[10] = '{47, 7,  3, 1, 1, 0, 0, 0};
        tbl[11] = '{9,  0,  4, 1, 0, 0, 0, 0};

        rst_n = 1'b0;
        hs_a = 1'b1; vs_a = 1'b1; hs_b = 1'b1; vs_b = 1'b1;
        repeat (3) tick();

        // Reset values of both instances.
        check("rst_h_a", int'(h_a), 0);
        check("rst_v_a", int'(v_a), 0);
        check("rst_lk_a", int'(lk_a), 0);
        check("rst_vid_a", int'(vid_a), 0);
        check("rst_st_a", int'(st_a), 0);
        check("rst_h_b", int'(h_b), 0);
        check("rst_v_b", int'(v_b), 0);
        check("rst_lk_b", int'(lk_b), 0);
        check("rst_fs_b", int'(fs_b), 0);
        check("rst_se_b", int'(se_b), 0);
        check("rst_ec_b", int'(ec_b), 0);
        rst_n = 1'b1;

        // ---- dut_a: default 640x480 constants over the first lines ----
        run_to_a(0, 655);
        check("a_free_h", int'(h_a), 656);
        step_a();
        check("a_force_h", int'(h_a), 656);
        step_a();
        check("a_h657", int'(h_a), 657);
        check("a_st_acq", int'(st_a), 1);
        run_to_a(0, 799);
        check("a_h799", int'(h_a), 799);
        check("a_v0", int'(v_a), 0);
        step_a();
        check("a_wrap_h", int'(h_a), 0);
        check("a_wrap_v", int'(v_a), 1);
        check("a_vid_unlocked", int'(vid_a), 0);
        run_to_a(1, 752);
        check("a_h752", int'(h_a), 752);
        check("a_se_acq", int'(se_a), 0);
        run_to_a(2, 659);
        check("a_h659", int'(h_a), 659);
        check("a_v2", int'(v_a), 2);
        check("a_st_acq2", int'(st_a), 1);
        check("a_lk", int'(lk_a), 0);

        // ---- dut_b: reset, then ideal timing from (0,0) ----
        rst_n = 1'b0;
        hs_a = 1'b1; vs_a = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        gbh = 0; gbv = 0;

        for (int i = 0; i < 12; i++) begin
            for (int s = 0; s < tbl[i].steps; s++) step_b();
            check($sformatf("tbl%0d_h", i), int'(h_b), tbl[i].h);
            check($sformatf("tbl%0d_v", i), int'(v_b), tbl[i].v);
            check($sformatf("tbl%0d_lk", i), int'(lk_b), tbl[i].lk);
            check($sformatf("tbl%0d_vid", i), int'(vid_b), tbl[i].vid);
            check($sformatf("tbl%0d_fs", i), int'(fs_b), tbl[i].fs);
            check($sformatf("tbl%0d_se", i), int'(se_b), tbl[i].se);
            check($sformatf("tbl%0d_ec", i), int'(ec_b), tbl[i].ec);
        end

        // One full locked frame: one frame_start, HA*VA active cycles, no errors.
        cnt_fs = 0; cnt_vid = 0; cnt_se = 0;
        for (int s = 0; s < HT * VT; s++) begin
            step_b();
            cnt_fs += int'(fs_b);
            cnt_vid += int'(vid_b);
            cnt_se += int'(se_b);
        end
        check("frame_fs", cnt_fs, 1);
        check("frame_vid", cnt_vid, HA * VA);
        check("frame_se", cnt_se, 0);
        check("frame_ec", int'(ec_b), 0);

        // hsync fall three cycles early on line 6 while locked.
        run_to_b(6, 6);
        early_b = 3;
        step_b();
        check("early_se", int'(se_b), 1);
        check("early_h_forced", int'(h_b), HSS);
        check("early_lk_same", int'(lk_b), 1);
        step_b();
        check("early_lk_next", int'(lk_b), 0);
        check("early_ec", int'(ec_b), 1);
        check("early_se_next", int'(se_b), 0);
        check("early_h_next", int'(h_b), HSS + 1);
        run_to_b(6, 9);
        early_b = 0;
        run_to_b(5, 0);
        check("relock_pre", int'(lk_b), 0);
        step_b();
        check("relock", int'(lk_b), 1);
        check("relock_v", int'(v_b), VSS);

        // hsync held high: timeout 1024 cycles after the hsync fall at (4,10).
        hold_b = 1'b1;
        steps = 0;
        while (se_b !== 1'b1 && steps < 1100) begin
            step_b();
            steps++;
        end
        if (se_b !== 1'b1) bound_fail("timeout_pulse");
        else check("timeout_cycles", steps, 1017);
        check("timeout_lk_same", int'(lk_b), 1);
        step_b();
        check("timeout_lk", int'(lk_b), 0);
        check("timeout_st", int'(st_b), 0);
        check("timeout_ec", int'(ec_b), 2);
        hold_b = 1'b0;
        run_to_b(5, 1);
        check("timeout_nolock", int'(lk_b), 0);
        run_to_b(5, 0);
        step_b();
        check("timeout_relock", int'(lk_b), 1);

        // Repeated errors with relock between: error_count saturates at 255.
        total_err = 2;
        for (int i = 0; i < 298; i++) begin
            run_to_b(6, 6);
            early_b = 3;
            step_b();
            check("sat_pulse", int'(se_b), 1);
            run_to_b(6, 9);
            early_b = 0;
            total_err++;
            exp_q.push_back((total_err > 255) ? 8'd255 : 8'(total_err));
            run_to_b(5, 1);
            e = exp_q.pop_front();
            check($sformatf("sat_ec%0d", total_err), int'(ec_b), int'(e));
            check("sat_relock", int'(lk_b), 1);
        end

        // Asynchronous reset mid-line while locked, then full relock.
        run_to_b(0, 3);
        check("mid_lk", int'(lk_b), 1);
        check("mid_vid", int'(vid_b), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_h", int'(h_b), 0);
        check("arst_v", int'(v_b), 0);
        check("arst_lk", int'(lk_b), 0);
        check("arst_vid", int'(vid_b), 0);
        check("arst_ec", int'(ec_b), 0);
        check("arst_st", int'(st_b), 0);
        step_b();
        check("arst_hold_h", int'(h_b), 0);
        rst_n = 1'b1;
        run_to_b(0, 9);
        check("post_rst_h", int'(h_b), 5);
        step_b();
        check("post_rst_force", int'(h_b), HSS);
        run_to_b(5, 0);
        check("post_rst_nolock", int'(lk_b), 0);
        step_b();
        check("post_rst_lock", int'(lk_b), 1);
        check("post_rst_ec", int'(ec_b), 0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
